caslock_key_loader: RTL and testbench
=====================================

// Module: caslock_key_loader
// PURPOSE
//   Provisioning side of the CAS-Lock key interface. Receives the secret key serially
//   (MSB first) with an 8-bit fold checksum, verifies it, and only then drives
//   keyinput[KEY_W-1:0] into the locked combinational netlist.
//   Until it is armed, keyinput is held at all-zero, which is a wrong key, so the
//   protected circuit stays corrupted. Counts failed loads and enters permanent
//   lockout after MAX_FAIL failures.
// PARAMETERS
//   KEY_W     64  key width; must equal the locked netlist's keyinput count, multiple of CHK_W
//   CHK_W     8   checksum width; chk = XOR of all CHK_W-bit slices of the key
//   MAX_FAIL  3   cumulative failed loads (since reset) that trigger LOCKOUT
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   load_start  in   1      pulse: begin a new key load
//   ser_valid   in   1      serial bit valid
//   ser_data    in   1      serial bit (key MSB first, then checksum MSB first)
//   ser_ready   out  1      loader accepts a bit this cycle
//   keyinput    out  KEY_W  key to the locked netlist; 0 unless ARMED
//   key_valid   out  1      high while ARMED
//   load_err    out  1      sticky until next load_start; last load failed its checksum
//   lockout     out  1      high in LOCKOUT
//   fail_cnt    out  2      failed-load count, saturating at MAX_FAIL
// BEHAVIOUR
//   Reset (async, any state): all outputs 0, state IDLE, shift/bit counters 0, fail_cnt 0.
//   States: IDLE, LOAD_KEY, LOAD_CHK, VERIFY, ARMED, ERROR, LOCKOUT.
//   Handshake: a bit is taken only on an edge where ser_valid && ser_ready. ser_ready is 1
//     only in LOAD_KEY and LOAD_CHK. ser_valid in any other state is ignored.
//   IDLE/ERROR/ARMED + load_start -> LOAD_KEY next edge. Shadow key, bit counter and
//     load_err clear. In ARMED, keyinput is zeroed and key_valid drops on that same edge.
//   LOAD_KEY: shift the bit into the shadow register. After KEY_W bits -> LOAD_CHK.
//   LOAD_CHK: shift into the chk register. After CHK_W bits -> VERIFY.
//   VERIFY: lasts 1 cycle.
//     Match    -> ARMED: keyinput <= shadow, key_valid=1 (2nd edge after last handshake).
//     Mismatch -> fail_cnt+1; next state LOCKOUT if the new count == MAX_FAIL, else ERROR
//                 with load_err=1.
//   load_start during LOAD_KEY/LOAD_CHK: restart (counters cleared, no failure counted).
//     If load_start and a valid bit coincide, the restart wins and the bit is dropped.
//   load_start in VERIFY: ignored.
//   LOCKOUT: terminal until rst_n. keyinput=0, ser_ready=0, load_start ignored.
//   fail_cnt is never cleared by a successful load.
//   The shadow register is never visible on keyinput except in ARMED.
// CONFIGURATION
//   CASLOCK_KEY_ZEROIZE_EN defined:
//     adds input key_zeroize (1 bit). While high, from any state except LOCKOUT:
//     state -> IDLE, shadow/keyinput/chk cleared, key_valid=0 on the next edge.
//     It has priority over load_start. fail_cnt is preserved.
//   Undefined: the port is absent. Only reset or a reload clears the key.
// STRUCTURE
//   Package caslock_pkg: state enum caslock_ld_st_e, CASLOCK_KEY_W=64, CASLOCK_CHK_W=8,
//     function chk_fold(key) returning CHK_W bits.
//   Sub-module caslock_key_sipo:
//     parameterised serial-in/parallel-out shift register with bit counter and done
//     flag, instantiated twice (key, checksum). FSM and fail counter live in the top.
// TESTING
//   1. Reset, load key 64'hDEAD_BEEF_0000_0001 with chk 8'h23, ser_valid constant
//      -> ser_ready high for 72 bits; key_valid=1 and keyinput=64'hDEAD_BEEF_0000_0001
//      two edges after the 72nd handshake.
//   2. Same key, chk 8'h24 -> load_err=1, fail_cnt=1, keyinput stays 0.
//      Then a correct load -> ARMED, fail_cnt stays 1.
//   3. Three bad loads -> lockout=1, fail_cnt=3, ser_ready=0.
//      load_start plus a correct key -> no change until rst_n pulse; after it all outputs 0.
//   4. ser_valid toggling 1-0-1 and load_start at bit 40 then full correct load
//      -> restart, no failure counted, ARMED with the new key.
//   5. rst_n asserted asynchronously mid-LOAD_CHK and while ARMED
//      -> keyinput=0, key_valid=0 immediately, no clock needed.
//   6. (CASLOCK_KEY_ZEROIZE_EN) ARMED, pulse key_zeroize
//      -> keyinput=0 and key_valid=0 next edge, state IDLE, fail_cnt unchanged.

Source files
------------

// File: rtl/caslock_pkg.sv
// Shared types, sizes and the checksum fold for the CAS-Lock key loader.
package caslock_pkg;

  localparam int CASLOCK_KEY_W    = 64;
  localparam int CASLOCK_CHK_W    = 8;
  localparam int CASLOCK_MAX_FAIL = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_CHK = 3'd2,
    ST_VERIFY   = 3'd3,
    ST_ARMED    = 3'd4,
    ST_ERROR    = 3'd5,
    ST_LOCKOUT  = 3'd6
  } caslock_ld_st_e;

  // XOR of every CHK_W-bit slice of the key.
  function automatic logic [CASLOCK_CHK_W-1:0] chk_fold(input logic [CASLOCK_KEY_W-1:0] key);
    logic [CASLOCK_CHK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < CASLOCK_KEY_W / CASLOCK_CHK_W; i++) begin
      acc = acc ^ key[i*CASLOCK_CHK_W +: CASLOCK_CHK_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/caslock_key_sipo.sv
// Serial-in/parallel-out shift register (MSB first) with bit counter.
// last_o flags the final free slot so the FSM can leave on the filling handshake.
module caslock_key_sipo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         done_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign data_o = data_q;
  assign last_o = (cnt_q == CW'(W - 1));
  assign done_o = (cnt_q == CW'(W));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (en_i && !done_o) begin
      data_d = {data_q[W-2:0], bit_i};
      cnt_d  = cnt_q + CW'(1);
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/caslock_key_loader.sv
// CAS-Lock key loader: serial key + fold checksum, verify, then drive keyinput.
// Optional CASLOCK_KEY_ZEROIZE_EN adds key_zeroize_i to wipe the key outside LOCKOUT.
module caslock_key_loader
  import caslock_pkg::*;
#(
  parameter int KEY_W    = CASLOCK_KEY_W,
  parameter int CHK_W    = CASLOCK_CHK_W,
  parameter int MAX_FAIL = CASLOCK_MAX_FAIL
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             ser_valid_i,
  input  logic             ser_data_i,
`ifdef CASLOCK_KEY_ZEROIZE_EN
  input  logic             key_zeroize_i,
`endif
  output logic             ser_ready_o,
  output logic [KEY_W-1:0] keyinput_o,
  output logic             key_valid_o,
  output logic             load_err_o,
  output logic             lockout_o,
  output logic [1:0]       fail_cnt_o
);

  caslock_ld_st_e   st_q, st_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             kv_q, kv_d, err_q, err_d, lock_q, lock_d;
  logic [1:0]       fail_q, fail_d;
  logic             clr_s, hs_s, zeroize_s;
  logic [KEY_W-1:0] shadow_s;
  logic [CHK_W-1:0] chk_s;
  logic             key_last_s, key_done_s, chk_last_s, chk_done_s, match_s;
  logic [1:0]       fail_inc_s;

`ifdef CASLOCK_KEY_ZEROIZE_EN
  assign zeroize_s = key_zeroize_i && (st_q != ST_LOCKOUT);
`else
  assign zeroize_s = 1'b0;
`endif

  assign ser_ready_o = (st_q == ST_LOAD_KEY) || (st_q == ST_LOAD_CHK);
  assign hs_s        = ser_valid_i && ser_ready_o;
  assign match_s     = key_done_s && chk_done_s && (chk_fold(shadow_s) == chk_s);
  assign fail_inc_s  = fail_q + 2'd1;

  caslock_key_sipo #(.W(KEY_W)) u_key_sipo (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (clr_s),
    .en_i  (hs_s && (st_q == ST_LOAD_KEY)), .bit_i (ser_data_i),
    .data_o(shadow_s), .last_o (key_last_s), .done_o (key_done_s)
  );

  caslock_key_sipo #(.W(CHK_W)) u_chk_sipo (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (clr_s),
    .en_i  (hs_s && (st_q == ST_LOAD_CHK)), .bit_i (ser_data_i),
    .data_o(chk_s), .last_o (chk_last_s), .done_o (chk_done_s)
  );

  // Restart (load_start) always wins over a coincident serial bit via clr_s.
  always_comb begin
    st_d   = st_q;
    key_d  = key_q;
    kv_d   = kv_q;
    err_d  = err_q;
    lock_d = lock_q;
    fail_d = fail_q;
    clr_s  = 1'b0;
    if (zeroize_s) begin
      st_d  = ST_IDLE;
      key_d = '0;
      kv_d  = 1'b0;
      clr_s = 1'b1;
    end else begin
      case (st_q)
        ST_IDLE, ST_ERROR, ST_ARMED: begin
          if (load_start_i) begin
            st_d  = ST_LOAD_KEY;
            key_d = '0;
            kv_d  = 1'b0;
            err_d = 1'b0;
            clr_s = 1'b1;
          end else begin
            st_d = st_q;
          end
        end
        ST_LOAD_KEY: begin
          if (load_start_i) begin
            clr_s = 1'b1;
          end else if (hs_s && key_last_s) begin
            st_d = ST_LOAD_CHK;
          end else begin
            st_d = ST_LOAD_KEY;
          end
        end
        ST_LOAD_CHK: begin
          if (load_start_i) begin
            st_d  = ST_LOAD_KEY;
            clr_s = 1'b1;
          end else if (hs_s && chk_last_s) begin
            st_d = ST_VERIFY;
          end else begin
            st_d = ST_LOAD_CHK;
          end
        end
        ST_VERIFY: begin
          if (match_s) begin
            st_d  = ST_ARMED;
            key_d = shadow_s;
            kv_d  = 1'b1;
          end else begin
            fail_d = fail_inc_s;
            err_d  = 1'b1;
            if (fail_inc_s == 2'(MAX_FAIL)) begin
              st_d   = ST_LOCKOUT;
              lock_d = 1'b1;
            end else begin
              st_d = ST_ERROR;
            end
          end
        end
        ST_LOCKOUT: begin
          st_d   = ST_LOCKOUT;
          key_d  = '0;
          kv_d   = 1'b0;
          lock_d = 1'b1;
        end
        default: begin
          st_d  = ST_IDLE;
          key_d = '0;
          kv_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ST_IDLE;
      key_q  <= '0;
      kv_q   <= 1'b0;
      err_q  <= 1'b0;
      lock_q <= 1'b0;
      fail_q <= 2'd0;
    end else begin
      st_q   <= st_d;
      key_q  <= key_d;
      kv_q   <= kv_d;
      err_q  <= err_d;
      lock_q <= lock_d;
      fail_q <= fail_d;
    end
  end

  assign keyinput_o  = key_q;
  assign key_valid_o = kv_q;
  assign load_err_o  = err_q;
  assign lockout_o   = lock_q;
  assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_caslock_key_loader.sv
// Directed, table-driven bench for caslock_key_loader.
module tb_caslock_key_loader;

  localparam logic [63:0] K1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_ready;
  logic [63:0] keyinput;
  logic        key_valid, load_err, lockout;
  logic [1:0]  fail_cnt;
`ifdef CASLOCK_KEY_ZEROIZE_EN
  logic        key_zeroize = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] key;
    logic [7:0]  chk;
    logic        exp_kv;
    logic        exp_err;
    logic        chk_err;
    logic [1:0]  exp_fail;
    logic        exp_lock;
    logic [63:0] exp_key;
  } vec_t;

  vec_t vecs[6];

  caslock_key_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_start_i (load_start),
    .ser_valid_i  (ser_valid),
    .ser_data_i   (ser_data),
`ifdef CASLOCK_KEY_ZEROIZE_EN
    .key_zeroize_i(key_zeroize),
`endif
    .ser_ready_o  (ser_ready),
    .keyinput_o   (keyinput),
    .key_valid_o  (key_valid),
    .load_err_o   (load_err),
    .lockout_o    (lockout),
    .fail_cnt_o   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".keyinput"}, keyinput, 64'd0);
    check({name, ".flags"}, {59'd0, ser_ready, key_valid, load_err, lockout, 1'b0},
          64'd0);
    check({name, ".fail_cnt"}, {62'd0, fail_cnt}, 64'd0);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after n accepted bits.
  task automatic send_bits(input logic [71:0] s, input int n, input bit toggle,
                           output int rdy_miss);
    int i;
    bit ph;
    i = 0;
    ph = 1'b0;
    rdy_miss = 0;
    while (i < n) begin
      ser_valid = !toggle || !ph;
      ser_data  = s[71-i];
      if (ser_valid && !ser_ready) rdy_miss++;
      @(posedge clk);
      if (ser_valid) i++;
      ph = ~ph;
      @(negedge clk);
    end
    ser_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int miss;
    vecs[0] = '{K1, 8'h23, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, K1};
    vecs[1] = '{K1, 8'h24, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 64'd0};
    vecs[2] = '{K1, 8'h23, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, K1};
    vecs[3] = '{K2, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, K2};
    vecs[4] = '{K2, 8'h01, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 64'd0};
    vecs[5] = '{K1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 64'd0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    for (int v = 0; v < 6; v++) begin
      start_load();
      send_bits({vecs[v].key, vecs[v].chk}, 72, 1'b0, miss);
      check($sformatf("v%0d.ready", v), 64'(miss), 64'd0);
      check($sformatf("v%0d.verify_kv", v), {63'd0, key_valid}, 64'd0);
      check($sformatf("v%0d.verify_key", v), keyinput, 64'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d.key_valid", v), {63'd0, key_valid}, {63'd0, vecs[v].exp_kv});
      check($sformatf("v%0d.keyinput", v), keyinput, vecs[v].exp_key);
      check($sformatf("v%0d.fail_cnt", v), {62'd0, fail_cnt}, {62'd0, vecs[v].exp_fail});
      check($sformatf("v%0d.lockout", v), {63'd0, lockout}, {63'd0, vecs[v].exp_lock});
      if (vecs[v].chk_err)
        check($sformatf("v%0d.load_err", v), {63'd0, load_err}, {63'd0, vecs[v].exp_err});
    end

    // Lockout is terminal: a correct load is ignored.
    check("lock.ready", {63'd0, ser_ready}, 64'd0);
    start_load();
    send_bits({K1, 8'h23}, 72, 1'b0, miss);
    repeat (2) @(negedge clk);
    check("lock.no_ready", 64'(miss), 64'd72);
    check("lock.lockout", {63'd0, lockout}, 64'd1);
    check("lock.key", keyinput, 64'd0);
    check("lock.kv", {63'd0, key_valid}, 64'd0);
    check("lock.fail", {62'd0, fail_cnt}, 64'd3);
    reset_pulse();
    check_all_zero("post_lock_reset");

    // Restart at bit 40 with toggling valid; coincident bit dropped.
    start_load();
    send_bits({K1, 8'h23}, 40, 1'b1, miss);
    load_start = 1'b1;
    ser_valid  = 1'b1;
    ser_data   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    ser_valid  = 1'b0;
    send_bits({K2, 8'h00}, 72, 1'b1, miss);
    check("restart.ready", 64'(miss), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("restart.kv", {63'd0, key_valid}, 64'd1);
    check("restart.key", keyinput, K2);
    check("restart.fail", {62'd0, fail_cnt}, 64'd0);
    check("restart.err", {63'd0, load_err}, 64'd0);

    // load_start during VERIFY is ignored.
    start_load();
    send_bits({K1, 8'h23}, 72, 1'b0, miss);
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    check("verify_ls.kv", {63'd0, key_valid}, 64'd1);
    check("verify_ls.key", keyinput, K1);

    // Async reset while ARMED.
    #1 rst_n = 1'b0;
    #1 check("rst_armed.kv", {63'd0, key_valid}, 64'd0);
    check("rst_armed.key", keyinput, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-LOAD_CHK after one failure.
    start_load();
    send_bits({K1, 8'h99}, 72, 1'b0, miss);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst.fail", {62'd0, fail_cnt}, 64'd1);
    start_load();
    send_bits({K1, 8'h23}, 66, 1'b0, miss);
    check("mid_chk.ready", {63'd0, ser_ready}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_chk");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CASLOCK_KEY_ZEROIZE_EN
    start_load();
    send_bits({K1, 8'h24}, 72, 1'b0, miss);
    @(posedge clk);
    @(negedge clk);
    start_load();
    send_bits({K1, 8'h23}, 72, 1'b0, miss);
    @(posedge clk);
    @(negedge clk);
    check("zer.armed", {63'd0, key_valid}, 64'd1);
    key_zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_zeroize = 1'b0;
    check("zer.kv", {63'd0, key_valid}, 64'd0);
    check("zer.key", keyinput, 64'd0);
    check("zer.fail", {62'd0, fail_cnt}, 64'd1);
    check("zer.idle_ready", {63'd0, ser_ready}, 64'd0);
    start_load();
    check("zer.reload_ready", {63'd0, ser_ready}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
